fetch_issue_buffer: RTL and testbench
=====================================

# fetch_issue_buffer

Dual-lane instruction buffer between the fetch stage and decode/issue in the 2-wide superscalar core. It accepts up to two fetched instructions per cycle with their PCs and holds them in a circular queue. It presents the two oldest entries, in program order, to the issue logic, which may consume 0, 1 or 2 per cycle. A flush empties it on branch redirect.

## Interface
Parameters:
- Depth, 8: queue entries. Power of two, ≥ 4.
- XLEN, from riscv_pkg (32): PC and instruction width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rstn_i  in  1  asynchronous active-low reset
- flush_i  in  1  discard all contents; this cycle's enqueue is dropped
- in_valid_i[2]  in  1 each  lane k carries a fetched instruction
- in_pc_i[2]  in  XLEN each  PC of lane k
- in_instr_i[2]  in  XLEN each  instruction word of lane k
- in_ready_o  out  1  buffer can accept two instructions this cycle
- out_valid_o[2]  out  1 each  output lane k holds the k-th oldest entry
- out_pc_o[2]  out  XLEN each  PC of output lane k; 0 when the lane is invalid
- out_instr_o[2]  out  XLEN each  instruction of output lane k; 0 when the lane is invalid
- out_take_i[2]  in  1 each  issue logic consumes output lane k this cycle
- count_o  out  $clog2(Depth)+1  number of occupied entries

## Operation
- Storage: Depth entries of {pc, instr}. Read pointer rd_ptr and write pointer wr_ptr are each $clog2(Depth) bits and wrap modulo Depth. An occupancy counter cnt runs 0..Depth.
- Enqueue:
  - Occurs when in_ready_o=1 and flush_i=0.
  - Valid lanes are written in lane order and compacted: if lane 0 is invalid and lane 1 is valid, lane 1 goes to slot wr_ptr.
  - wr_ptr advances by the number of valid lanes, written as n_in.
  - When in_ready_o=0, inputs are ignored and fetch must hold.
- in_ready_o = (cnt ≤ Depth−2). It is computed from the registered count only and does not credit same-cycle dequeues.
- Output lanes:
  - Lane 0 shows the entry at rd_ptr and is valid when cnt ≥ 1.
  - Lane 1 shows the entry at rd_ptr+1 (wrapping) and is valid when cnt ≥ 2.
- Dequeue:
  - n_out = out_take_i[0]&out_valid_o[0] + (out_take_i[1]&out_valid_o[1]&out_take_i[0]).
  - out_take_i[1] without out_take_i[0] is ignored, so issue is in order.
  - Takes on invalid lanes are ignored.
  - rd_ptr advances by n_out.
- Count: cnt_next = cnt + n_in − n_out. Simultaneous enqueue and dequeue is legal at any occupancy, including wrap of either pointer.
- Flush:
  - rd_ptr, wr_ptr and cnt all become 0 at the next edge.
  - During the flush cycle, out_valid_o is forced to 0 combinationally and out_take_i is ignored.
  - Flush has priority over enqueue and dequeue.
- Reset (asynchronous, rstn_i=0):
  - rd_ptr=0, wr_ptr=0, cnt=0.
  - Outputs: in_ready_o=1, out_valid_o={0,0}, out_pc_o={0,0}, out_instr_o={0,0}, count_o=0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all entries immediately.

## Timing
- Enqueue-to-output latency is 1 cycle. An instruction written at edge N is visible on out lanes after edge N.
- count_o, in_ready_o and out_valid_o change only after clock edges. The exceptions are flush masking, and bypass when compiled in.
- Full boundary: at cnt=Depth−1, in_ready_o=0 even if a dequeue happens in the same cycle.
- Empty boundary: at cnt=0 both out_valid_o are 0 (without bypass). At cnt=1 only lane 0 is valid.
- Throughput: a sustained 2 in / 2 out per cycle holds cnt constant.

## Configuration
- ISSUE_BUF_BYPASS_EN defined:
  - When cnt=0 and flush_i=0, the compacted input lanes drive the output lanes combinationally in the same cycle, so out_valid_o follows in_valid_i.
  - Bypassed lanes that are taken are not written into storage.
  - Untaken bypassed lanes are enqueued normally.
  - Zero-latency path on an empty buffer.
- Not defined: no combinational path from in_* to out_*; latency is always 1 cycle.

## Test plan
- Reset, then enqueue lanes {pc 0x00, 0x04}, no take → next cycle out_valid_o={1,1}, out_pc_o={0x00,0x04}, count_o=2.
- in_valid_i={0,1} with pc 0x10 on lane 1, into an empty buffer → next cycle out_valid_o={1,0}, out_pc_o[0]=0x10, count_o=1.
- Fill Depth=8 to cnt=6, then enqueue 2 → cnt=8, in_ready_o=0. Further inputs are ignored and count_o stays 8 until a take.
- Sustain 2-in/2-out for 20 cycles → PCs emerge strictly in order across a pointer wrap, and count_o stays constant.
- Take pattern out_take_i={0,1} at cnt=3 → ignored, count_o stays 3. Then take {1,1} → count_o=1.
- At cnt=5, assert flush_i together with a valid enqueue → during that cycle out_valid_o={0,0}. Next cycle count_o=0 and in_ready_o=1. Repeat with rstn_i pulsed low mid-stream → outputs are zero immediately.

Source files
------------

// File: rtl/fetch_issue_buffer.sv
// Dual-lane circular instruction queue between fetch and decode/issue (2 in, 2 out per cycle).
// Optional zero-latency empty-buffer bypass is compiled in when ISSUE_BUF_BYPASS_EN is defined.
module fetch_issue_buffer #(
   parameter int Depth = 8,
   parameter int XLEN  = 32
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      flush_i,
   input  logic [1:0]                in_valid_i,
   input  logic [1:0][XLEN-1:0]      in_pc_i,
   input  logic [1:0][XLEN-1:0]      in_instr_i,
   output logic                      in_ready_o,
   output logic [1:0]                out_valid_o,
   output logic [1:0][XLEN-1:0]      out_pc_o,
   output logic [1:0][XLEN-1:0]      out_instr_o,
   input  logic [1:0]                out_take_i,
   output logic [$clog2(Depth):0]    count_o
);

   localparam int AW = $clog2(Depth);
   localparam int CW = AW + 1;

   logic [XLEN-1:0]      r_memPc    [Depth];
   logic [XLEN-1:0]      r_memInstr [Depth];
   logic [AW-1:0]        r_rdPtr;
   logic [AW-1:0]        r_wrPtr;
   logic [CW-1:0]        r_cnt;

   logic                 w_enq;
   logic                 w_bypass;
   logic [1:0]           w_cmpValid;
   logic [1:0][XLEN-1:0] w_cmpPc;
   logic [1:0][XLEN-1:0] w_cmpInstr;
   logic [1:0][XLEN-1:0] w_lanePc;
   logic [1:0][XLEN-1:0] w_laneInstr;
   logic [1:0][XLEN-1:0] w_wrPc;
   logic [1:0][XLEN-1:0] w_wrInstr;
   logic [1:0]           w_nIn;
   logic [1:0]           w_nOut;
   logic [1:0]           w_skip;
   logic [1:0]           w_nWr;
   logic [1:0]           w_rdAdv;
   logic [AW-1:0]        w_rdIdx1;
   logic [AW-1:0]        w_wrIdx1;

   // Ready looks only at the registered count so fetch never depends on this cycle's takes.
   assign in_ready_o = (r_cnt <= CW'(Depth - 2));
   assign w_enq      = in_ready_o & ~flush_i;
   assign count_o    = r_cnt;
   assign w_rdIdx1   = r_rdPtr + AW'(1);
   assign w_wrIdx1   = r_wrPtr + AW'(1);

   // Compact the valid input lanes so a lone lane-1 instruction lands in the first free slot.
   always_comb begin
      w_cmpValid = 2'b00;
      w_cmpPc    = '0;
      w_cmpInstr = '0;
      if (in_valid_i[0]) begin
         w_cmpValid    = {in_valid_i[1], 1'b1};
         w_cmpPc[0]    = in_pc_i[0];
         w_cmpInstr[0] = in_instr_i[0];
         w_cmpPc[1]    = in_pc_i[1];
         w_cmpInstr[1] = in_instr_i[1];
      end else if (in_valid_i[1]) begin
         w_cmpValid    = 2'b01;
         w_cmpPc[0]    = in_pc_i[1];
         w_cmpInstr[0] = in_instr_i[1];
      end
   end

   assign w_nIn = w_enq ? ({1'b0, w_cmpValid[0]} + {1'b0, w_cmpValid[1]}) : 2'd0;

   always_comb begin
      w_bypass       = 1'b0;
      out_valid_o[0] = ~flush_i & (r_cnt >= CW'(1));
      out_valid_o[1] = ~flush_i & (r_cnt >= CW'(2));
      w_lanePc[0]    = r_memPc[r_rdPtr];
      w_laneInstr[0] = r_memInstr[r_rdPtr];
      w_lanePc[1]    = r_memPc[w_rdIdx1];
      w_laneInstr[1] = r_memInstr[w_rdIdx1];
`ifdef ISSUE_BUF_BYPASS_EN
      if (r_cnt == '0 && !flush_i) begin
         w_bypass    = 1'b1;
         out_valid_o = w_cmpValid;
         w_lanePc    = w_cmpPc;
         w_laneInstr = w_cmpInstr;
      end
`endif
      for (int k = 0; k < 2; k++) begin
         out_pc_o[k]    = out_valid_o[k] ? w_lanePc[k]    : '0;
         out_instr_o[k] = out_valid_o[k] ? w_laneInstr[k] : '0;
      end
   end

   // Lane 1 only counts when lane 0 is also taken, keeping issue in program order.
   assign w_nOut = {1'b0, out_take_i[0] & out_valid_o[0]}
                 + {1'b0, out_take_i[1] & out_valid_o[1] & out_take_i[0]};

   // Bypassed lanes that issue are skipped at the write port rather than stored and popped.
   assign w_skip  = w_bypass ? w_nOut : 2'd0;
   assign w_nWr   = w_nIn - w_skip;
   assign w_rdAdv = w_bypass ? 2'd0 : w_nOut;

   assign w_wrPc[0]    = (w_skip == 2'd0) ? w_cmpPc[0]    : w_cmpPc[1];
   assign w_wrInstr[0] = (w_skip == 2'd0) ? w_cmpInstr[0] : w_cmpInstr[1];
   assign w_wrPc[1]    = w_cmpPc[1];
   assign w_wrInstr[1] = w_cmpInstr[1];

   always_ff @(posedge clk_i) begin
      if (w_enq && w_nWr >= 2'd1) begin
         r_memPc[r_wrPtr]    <= w_wrPc[0];
         r_memInstr[r_wrPtr] <= w_wrInstr[0];
      end
      if (w_enq && w_nWr == 2'd2) begin
         r_memPc[w_wrIdx1]    <= w_wrPc[1];
         r_memInstr[w_wrIdx1] <= w_wrInstr[1];
      end
   end

   // Flush outranks everything; with outputs masked, takes cannot slip through either.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_cnt   <= '0;
      end else if (flush_i) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_cnt   <= '0;
      end else begin
         r_rdPtr <= r_rdPtr + AW'(w_rdAdv);
         r_wrPtr <= r_wrPtr + AW'(w_nWr);
         r_cnt   <= r_cnt + CW'(w_nIn) - CW'(w_nOut);
      end
   end

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Scoreboard bench for fetch_issue_buffer: the driver queues accepted instructions, and a
// negedge monitor compares every output against a plain FIFO model of the buffer contents.
module tb_fetch_issue_buffer;

   localparam int DEPTH = 8;
   localparam int XLEN  = 32;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic                 clk_i      = 1'b0;
   logic                 rstn_i     = 1'b0;
   logic                 flush_i    = 1'b0;
   logic [1:0]           in_valid_i = 2'b00;
   logic [1:0][XLEN-1:0] in_pc_i    = '0;
   logic [1:0][XLEN-1:0] in_instr_i = '0;
   logic [1:0]           out_take_i = 2'b00;
   logic                 in_ready_o;
   logic [1:0]           out_valid_o;
   logic [1:0][XLEN-1:0] out_pc_o;
   logic [1:0][XLEN-1:0] out_instr_o;
   logic [$clog2(DEPTH):0] count_o;

   entry_t          expQ[$];
   entry_t          inFlight[$];
   int              checks = 0;
   int              errors = 0;
   logic [XLEN-1:0] nextPc = '0;

   fetch_issue_buffer #(.Depth(DEPTH), .XLEN(XLEN)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_pc_i     (in_pc_i),
      .in_instr_i  (in_instr_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_pc_o    (out_pc_o),
      .out_instr_o (out_instr_o),
      .out_take_i  (out_take_i),
      .count_o     (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs just after the edge; accepted lanes join the in-flight queue.
   task automatic applyStimulus(input logic [1:0] v, input logic [1:0] take, input logic fl);
      logic accept;
      entry_t e;
      @(posedge clk_i);
      #1;
      accept     = rstn_i && !fl && (expQ.size() <= DEPTH - 2);
      flush_i    = fl;
      out_take_i = take;
      in_valid_i = v;
      for (int k = 0; k < 2; k++) begin
         in_pc_i[k]    = '0;
         in_instr_i[k] = $urandom;
         if (v[k]) begin
            in_pc_i[k] = nextPc;
            if (accept) begin
               e.pc    = nextPc;
               e.instr = in_instr_i[k];
               inFlight.push_back(e);
               nextPc = nextPc + 4;
            end
         end
      end
   endtask

   task automatic pulseReset();
      @(posedge clk_i);
      #1;
      rstn_i     = 1'b0;
      in_valid_i = 2'b00;
      out_take_i = 2'b00;
      flush_i    = 1'b0;
      expQ.delete();
      inFlight.delete();
      #1;
      checkOutput("rst_count", XLEN'(count_o), '0);
      checkOutput("rst_valid", XLEN'(out_valid_o), '0);
      checkOutput("rst_pc0", out_pc_o[0], '0);
      checkOutput("rst_pc1", out_pc_o[1], '0);
      checkOutput("rst_ready", XLEN'(in_ready_o), 32'd1);
      @(posedge clk_i);
      #1;
      rstn_i = 1'b1;
   endtask

   always @(negedge clk_i) begin : monitor
      entry_t view[$];
      logic   fromIn;
      logic   v0;
      logic   v1;
      int     nOut;
      if (!rstn_i) begin
         expQ.delete();
         inFlight.delete();
         checkOutput("reset_count", XLEN'(count_o), '0);
         checkOutput("reset_ready", XLEN'(in_ready_o), 32'd1);
         checkOutput("reset_valid", XLEN'(out_valid_o), '0);
         for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("reset_pc%0d", k), out_pc_o[k], '0);
            checkOutput($sformatf("reset_instr%0d", k), out_instr_o[k], '0);
         end
      end else begin
         fromIn = 1'b0;
`ifdef ISSUE_BUF_BYPASS_EN
         if (expQ.size() == 0 && !flush_i) fromIn = 1'b1;
`endif
         if (fromIn) view = inFlight;
         else        view = expQ;
         v0 = !flush_i && view.size() >= 1;
         v1 = !flush_i && view.size() >= 2;
         checkOutput("count", XLEN'(count_o), XLEN'(expQ.size()));
         checkOutput("in_ready", XLEN'(in_ready_o), XLEN'(expQ.size() <= DEPTH - 2));
         checkOutput("valid0", XLEN'(out_valid_o[0]), XLEN'(v0));
         checkOutput("valid1", XLEN'(out_valid_o[1]), XLEN'(v1));
         for (int k = 0; k < 2; k++) begin
            logic [XLEN-1:0] ePc;
            logic [XLEN-1:0] eInstr;
            ePc    = '0;
            eInstr = '0;
            if ((k == 0 && v0) || (k == 1 && v1)) begin
               ePc    = view[k].pc;
               eInstr = view[k].instr;
            end
            checkOutput($sformatf("pc%0d", k), out_pc_o[k], ePc);
            checkOutput($sformatf("instr%0d", k), out_instr_o[k], eInstr);
         end
         if (flush_i) begin
            expQ.delete();
            inFlight.delete();
         end else begin
            nOut = int'(out_take_i[0] & v0) + int'(out_take_i[1] & v1 & out_take_i[0]);
            for (int i = 0; i < nOut; i++) begin
               if (fromIn) void'(inFlight.pop_front());
               else        void'(expQ.pop_front());
            end
            while (inFlight.size() > 0) expQ.push_back(inFlight.pop_front());
         end
      end
   end

   initial begin
      int pct;
      logic [1:0] take;
      repeat (2) @(posedge clk_i);
      #1;
      rstn_i = 1'b1;

      applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b11, 1'b0);

      nextPc = 32'h10;
      applyStimulus(2'b10, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b11, 1'b0);

      repeat (4) applyStimulus(2'b11, 2'b00, 1'b0);
      repeat (3) applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b11, 2'b01, 1'b0);
      applyStimulus(2'b11, 2'b11, 1'b0);
      repeat (5) applyStimulus(2'b00, 2'b11, 1'b0);

      applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b01, 2'b00, 1'b0);
      applyStimulus(2'b00, 2'b10, 1'b0);
      applyStimulus(2'b00, 2'b11, 1'b0);
      applyStimulus(2'b00, 2'b11, 1'b0);

      applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b11, 2'b00, 1'b0);
      repeat (20) applyStimulus(2'b11, 2'b11, 1'b0);

      applyStimulus(2'b01, 2'b00, 1'b0);
      applyStimulus(2'b11, 2'b11, 1'b1);
      applyStimulus(2'b00, 2'b00, 1'b0);

      applyStimulus(2'b11, 2'b00, 1'b0);
      applyStimulus(2'b11, 2'b01, 1'b0);
      pulseReset();
      applyStimulus(2'b00, 2'b00, 1'b0);

      for (int ph = 0; ph < 4; ph++) begin
         pct = (ph % 2 == 0) ? 80 : 25;
         for (int i = 0; i < 400; i++) begin
            take = ($urandom_range(0, 99) < pct) ? 2'($urandom_range(0, 3)) : 2'b00;
            if ($urandom_range(0, 299) == 0) pulseReset();
            else applyStimulus(2'($urandom_range(0, 3)), take, $urandom_range(0, 59) == 0);
         end
      end

      applyStimulus(2'b00, 2'b00, 1'b0);
      @(negedge clk_i);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
